cirno9_sram_arb: RTL and testbench
==================================

# cirno9_sram_arb

Three-requester arbiter that shares the core's single-ported synchronous SRAM between instruction fetch (port 0), load/store data (port 1) and the AXI-slave bridge (port 2). It sits between the core's fetch/LSU request paths and the SRAM macro. Each cycle it grants at most one request and drives the SRAM strobes. It steers the one-cycle-latency read data back to the granted port with a response strobe. Fetch has starvation protection.

## Interface
- `NPORT`, 3, number of requesters; fixed port roles as above
- `AW`, 32, address width
- `STARVE_MAX`, 8, cycles a pending port-0 request may lose before it is force-granted (1..255)

- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `i_req_val`  in  NPORT  request valid per port
- `o_req_rdy`  out  NPORT  grant per port; transfer when val&rdy
- `i_req_adr`  in  NPORT*AW  word address per port, port p at bits [p*AW +: AW]
- `i_req_wdat`  in  NPORT*32  write data per port
- `i_req_wen`  in  NPORT*4  byte write enables per port
- `i_req_ren`  in  NPORT  read enable per port
- `o_rsp_val`  out  NPORT  one-cycle completion strobe per port
- `o_rsp_rdat`  out  32  read data, shared; qualified by `o_rsp_val`
- `o_sram_ren`  out  1  SRAM read strobe
- `o_sram_wen`  out  4  SRAM byte write strobes
- `o_sram_adr`  out  AW  SRAM address
- `o_sram_wdat`  out  32  SRAM write data
- `i_sram_rdat`  in  32  SRAM read data, valid the cycle after `o_sram_ren`

## Operation
- Candidate set: ports with `i_req_val`=1. `o_req_rdy` is one-hot or zero and is combinational from the candidate set and the registered state.
- Priority without the macro is fixed: port 1 > port 2 > port 0. The starvation override beats both fixed and round-robin order.
- Starvation counter `starve_cnt` (8 bit):
  - increments when port 0 is valid and not granted.
  - clears when port 0 is granted or not valid.
  - when `starve_cnt` == STARVE_MAX, port 0 wins unconditionally.
- The SRAM strobes are the granted port's `ren`/`wen`/`adr`/`wdat`, passed combinationally. With no grant, `o_sram_ren`=0, `o_sram_wen`=0, and adr/wdat = 0.
- A request with `ren`=0 and `wen`=0 is still granted and completes as a no-op.
- A request with both `ren` and `wen` set is driven to the SRAM as given. It completes as a read.
- Response register `rsp_port` (one-hot, NPORT bits) latches the grant vector. `o_rsp_val` = `rsp_port` in the cycle after the grant, for reads, writes and no-ops alike.
- `o_rsp_rdat` = `i_sram_rdat` when the latched grant was a read, otherwise 0.
- Responses have no backpressure. Requesters must accept `o_rsp_val` in the cycle it is asserted.
- Requester rule: `i_req_val`/adr/data must stay stable until `o_req_rdy`. The arbiter does not register request payload.

## Timing
- Grant in cycle N → SRAM access in cycle N. `o_rsp_val`/`o_rsp_rdat` arrive in N+1.
- Fully pipelined: a new grant is allowed in N+1 while N's response is returned. Sustained throughput is 1 access/cycle.
- Simultaneous requests: exactly one grant per cycle. Losers keep `o_req_rdy`=0.
- Reset values: `o_rsp_val`=0, `rsp_port`=0, `starve_cnt`=0, round-robin pointer=0, read-flag=0.
- Assertion of `rst` in the cycle after a grant drops that grant's response: `o_rsp_val`=0 in the next cycle.
- During `rst`, all `o_req_rdy`=0 and the SRAM strobes are 0.

## Configuration
- `CIRNO9_SRAM_ARB_RR_EN`
  - Defined: round-robin among ports. A 2-bit pointer holds the last granted port. Search starts at pointer+1 mod NPORT. The pointer updates on every grant.
  - Undefined: fixed priority 1 > 2 > 0, and no pointer register exists.
  - In both cases the starvation override remains active.

## Structure
- Shared package/define file holds the port-index constants `CIRNO9_ARB_P_IF`=0, `CIRNO9_ARB_P_LS`=1 and `CIRNO9_ARB_P_AXIS`=2, plus the `STARVE_MAX` default.
- One sub-module, `cirno9_arb_pick`: combinational grant selection from the candidate vector, pointer and starve flag. It produces a one-hot grant and a binary index.
- The top module holds all registers and the SRAM/response muxing.

## Test plan
- Port 1 reads adr 0x10, SRAM returns 0xDEADBEEF → `o_req_rdy`=3'b010 in cycle N; in N+1, `o_rsp_val`=3'b010 and `o_rsp_rdat`=0xDEADBEEF.
- Ports 0, 1 and 2 all valid in one cycle, without the macro → grant order 1, 2, 0 over three cycles, each with a response one cycle later.
- Ports 0 and 1 continuously valid, STARVE_MAX=8 → port 0 is granted on cycle 9, then port 1 resumes.
- Macro defined, all three ports valid for 6 cycles → grants follow 1, 2, 0, 1, 2, 0.
- Port 2 writes wen=4'b0011, wdat=0x12345678 → `o_sram_wen`=4'b0011 in the grant cycle; next cycle `o_rsp_val`=3'b100 and `o_rsp_rdat`=0.
- Grant of a read, then `rst` high in the following cycle → `o_rsp_val`=0 and the counter/pointer return to 0.

Source files
------------

// File: rtl/cirno9_sram_arb_pkg.sv
// Shared constants for the cirno9 SRAM arbiter.
//   - Port-index constants for the three fixed requester roles.
//   - Default starvation threshold for the fetch port.
//   - Round-robin search helper used by the grant picker.
package cirno9_sram_arb_pkg;

  localparam int CIRNO9_ARB_NPORT      = 3;
  localparam int CIRNO9_ARB_P_IF       = 0;  // instruction fetch
  localparam int CIRNO9_ARB_P_LS       = 1;  // load/store
  localparam int CIRNO9_ARB_P_AXIS     = 2;  // AXI-slave bridge
  localparam int CIRNO9_ARB_STARVE_MAX = 8;

  // Port visited at search step k when the last grant went to ptr.
  function automatic int rr_port(input logic [1:0] ptr, input int k, input int n);
    return (int'(ptr) + 1 + k) % n;
  endfunction

endpackage

// File: rtl/cirno9_arb_pick.sv
// Combinational grant selection for the cirno9 SRAM arbiter.
// Build option: CIRNO9_SRAM_ARB_RR_EN selects round-robin order starting
// after i_ptr; otherwise fixed priority LS > AXIS > IF.
// Ports:
//   i_cand    candidate (valid) vector
//   i_ptr     last granted port (round-robin build only)
//   i_starve  fetch port is starved and valid; forces its grant
//   o_gnt     one-hot grant, zero when no candidate
//   o_idx     binary index of the granted port
module cirno9_arb_pick
  import cirno9_sram_arb_pkg::*;
#(
  parameter int NPORT = CIRNO9_ARB_NPORT
) (
  input  logic [NPORT-1:0] i_cand,
`ifdef CIRNO9_SRAM_ARB_RR_EN
  input  logic [1:0]       i_ptr,
`endif
  input  logic             i_starve,
  output logic [NPORT-1:0] o_gnt,
  output logic [1:0]       o_idx
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    if (i_starve) begin
      o_gnt[CIRNO9_ARB_P_IF] = 1'b1;
      o_idx                  = 2'(CIRNO9_ARB_P_IF);
    end else begin
`ifdef CIRNO9_SRAM_ARB_RR_EN
      for (int k = 0; k < NPORT; k++) begin
        if ((o_gnt == '0) && i_cand[rr_port(i_ptr, k, NPORT)]) begin
          o_gnt[rr_port(i_ptr, k, NPORT)] = 1'b1;
          o_idx                           = 2'(rr_port(i_ptr, k, NPORT));
        end
      end
`else
      if (i_cand[CIRNO9_ARB_P_LS]) begin
        o_gnt[CIRNO9_ARB_P_LS] = 1'b1;
        o_idx                  = 2'(CIRNO9_ARB_P_LS);
      end else if (i_cand[CIRNO9_ARB_P_AXIS]) begin
        o_gnt[CIRNO9_ARB_P_AXIS] = 1'b1;
        o_idx                    = 2'(CIRNO9_ARB_P_AXIS);
      end else if (i_cand[CIRNO9_ARB_P_IF]) begin
        o_gnt[CIRNO9_ARB_P_IF] = 1'b1;
        o_idx                  = 2'(CIRNO9_ARB_P_IF);
      end
`endif
    end
  end

endmodule

// File: rtl/cirno9_sram_arb.sv
// Three-requester arbiter for the core's single-ported synchronous SRAM.
// Grants at most one request per cycle, passes the winner's strobes to the
// SRAM combinationally and returns a one-cycle-later completion strobe with
// read data. The fetch port is force-granted after STARVE_MAX lost cycles.
// Build option: CIRNO9_SRAM_ARB_RR_EN enables round-robin order (with a
// last-grant pointer); default is fixed priority LS > AXIS > IF.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req_val/o_req_rdy      per-port request handshake
//   i_req_adr/wdat/wen/ren   per-port request payload (packed by port)
//   o_rsp_val, o_rsp_rdat    per-port completion strobe, shared read data
//   o_sram_*/i_sram_rdat     SRAM macro interface
module cirno9_sram_arb
  import cirno9_sram_arb_pkg::*;
#(
  parameter int NPORT      = CIRNO9_ARB_NPORT,
  parameter int AW         = 32,
  parameter int STARVE_MAX = CIRNO9_ARB_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    i_req_val,
  output logic [NPORT-1:0]    o_req_rdy,
  input  logic [NPORT*AW-1:0] i_req_adr,
  input  logic [NPORT*32-1:0] i_req_wdat,
  input  logic [NPORT*4-1:0]  i_req_wen,
  input  logic [NPORT-1:0]    i_req_ren,
  output logic [NPORT-1:0]    o_rsp_val,
  output logic [31:0]         o_rsp_rdat,
  output logic                o_sram_ren,
  output logic [3:0]          o_sram_wen,
  output logic [AW-1:0]       o_sram_adr,
  output logic [31:0]         o_sram_wdat,
  input  logic [31:0]         i_sram_rdat
);

  logic [NPORT-1:0] w_pick_gnt;
  logic [NPORT-1:0] w_gnt;
  logic [1:0]       w_idx;
  logic             w_any;
  logic             w_starve;

  logic [7:0]       r_starve_cnt;
  logic [NPORT-1:0] r_rsp_port;
  logic             r_rsp_rd;
`ifdef CIRNO9_SRAM_ARB_RR_EN
  logic [1:0]       r_ptr;
`endif

  assign w_starve = i_req_val[CIRNO9_ARB_P_IF] && (r_starve_cnt == 8'(STARVE_MAX));

  cirno9_arb_pick #(.NPORT(NPORT)) u_pick (
    .i_cand   (i_req_val),
`ifdef CIRNO9_SRAM_ARB_RR_EN
    .i_ptr    (r_ptr),
`endif
    .i_starve (w_starve),
    .o_gnt    (w_pick_gnt),
    .o_idx    (w_idx)
  );

  // No grant (and hence no SRAM access) while reset is held.
  assign w_gnt     = rst ? '0 : w_pick_gnt;
  assign w_any     = |w_gnt;
  assign o_req_rdy = w_gnt;

  always_comb begin
    o_sram_ren  = 1'b0;
    o_sram_wen  = '0;
    o_sram_adr  = '0;
    o_sram_wdat = '0;
    if (w_any) begin
      o_sram_ren  = i_req_ren[w_idx];
      o_sram_wen  = i_req_wen[int'(w_idx)*4 +: 4];
      o_sram_adr  = i_req_adr[int'(w_idx)*AW +: AW];
      o_sram_wdat = i_req_wdat[int'(w_idx)*32 +: 32];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_rsp_port   <= '0;
      r_rsp_rd     <= 1'b0;
    end else begin
      r_rsp_port <= w_gnt;
      // A read+write request completes as a read.
      r_rsp_rd   <= w_any && o_sram_ren;
      if (i_req_val[CIRNO9_ARB_P_IF] && !w_gnt[CIRNO9_ARB_P_IF]) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

`ifdef CIRNO9_SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_idx;
    end
  end
`endif

  // Reset in the response cycle suppresses the response already in flight.
  assign o_rsp_val  = rst ? '0 : r_rsp_port;
  assign o_rsp_rdat = (r_rsp_rd && !rst) ? i_sram_rdat : '0;

endmodule

// File: tb/tb_cirno9_sram_arb.sv
// Directed scoreboard bench for cirno9_sram_arb. Expected grants come from
// the stimulus tables; each granted request pushes its expected response,
// which is popped and compared in the following cycle.
module tb_cirno9_sram_arb;

  localparam int NPORT = 3;
  localparam int AW    = 32;

  logic                clk;
  logic                rst;
  logic [NPORT-1:0]    i_req_val;
  logic [NPORT-1:0]    o_req_rdy;
  logic [NPORT*AW-1:0] i_req_adr;
  logic [NPORT*32-1:0] i_req_wdat;
  logic [NPORT*4-1:0]  i_req_wen;
  logic [NPORT-1:0]    i_req_ren;
  logic [NPORT-1:0]    o_rsp_val;
  logic [31:0]         o_rsp_rdat;
  logic                o_sram_ren;
  logic [3:0]          o_sram_wen;
  logic [AW-1:0]       o_sram_adr;
  logic [31:0]         o_sram_wdat;
  logic [31:0]         i_sram_rdat;

  cirno9_sram_arb #(.NPORT(NPORT), .AW(AW), .STARVE_MAX(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_val   (i_req_val),
    .o_req_rdy   (o_req_rdy),
    .i_req_adr   (i_req_adr),
    .i_req_wdat  (i_req_wdat),
    .i_req_wen   (i_req_wen),
    .i_req_ren   (i_req_ren),
    .o_rsp_val   (o_rsp_val),
    .o_rsp_rdat  (o_rsp_rdat),
    .o_sram_ren  (o_sram_ren),
    .o_sram_wen  (o_sram_wen),
    .o_sram_adr  (o_sram_adr),
    .o_sram_wdat (o_sram_wdat),
    .i_sram_rdat (i_sram_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NPORT-1:0] port;
    logic             rd;
  } rsp_t;

  rsp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic val, input logic ren, input logic [3:0] wen,
                          input logic [31:0] adr, input logic [31:0] wdat);
    i_req_val[p]          = val;
    i_req_ren[p]          = ren;
    i_req_wen[p*4 +: 4]   = wen;
    i_req_adr[p*AW +: AW] = adr;
    i_req_wdat[p*32 +: 32] = wdat;
  endtask

  task automatic clr_port(input int p);
    set_port(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // One clock cycle: check grant/strobes/response mid-cycle, then advance.
  task automatic step(input string tag, input logic [NPORT-1:0] exp_gnt, input logic [31:0] rdat);
    rsp_t e;
    int   idx;
    i_sram_rdat = rdat;
    @(negedge clk);
    #1;
    check({tag, ".rdy"}, 32'(o_req_rdy), 32'(exp_gnt));
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, ".rsp_val"}, 32'(o_rsp_val), 32'(e.port));
      check({tag, ".rsp_rdat"}, o_rsp_rdat, e.rd ? rdat : 32'h0);
    end else begin
      check({tag, ".rsp_val0"}, 32'(o_rsp_val), 32'h0);
      check({tag, ".rsp_rdat0"}, o_rsp_rdat, 32'h0);
    end
    if (exp_gnt != '0) begin
      idx = exp_gnt[1] ? 1 : (exp_gnt[2] ? 2 : 0);
      check({tag, ".sram_ren"}, 32'(o_sram_ren), 32'(i_req_ren[idx]));
      check({tag, ".sram_wen"}, 32'(o_sram_wen), 32'(i_req_wen[idx*4 +: 4]));
      check({tag, ".sram_adr"}, o_sram_adr, i_req_adr[idx*AW +: AW]);
      check({tag, ".sram_wdat"}, o_sram_wdat, i_req_wdat[idx*32 +: 32]);
      e.port = exp_gnt;
      e.rd   = i_req_ren[idx];
      q.push_back(e);
    end else begin
      check({tag, ".sram_idle"}, {27'h0, o_sram_ren, o_sram_wen}, 32'h0);
      check({tag, ".sram_adr0"}, o_sram_adr | o_sram_wdat, 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [NPORT-1:0] rr_seq [3];

  initial begin
    rr_seq = '{3'b010, 3'b100, 3'b001};
    rst = 1'b1;
    i_req_val = '0; i_req_ren = '0; i_req_wen = '0; i_req_adr = '0; i_req_wdat = '0;
    i_sram_rdat = '0;

    // Reset state.
    step("reset0", 3'b000, $urandom());
    set_port(1, 1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    step("reset1", 3'b000, $urandom());
    rst = 1'b0;

    // Port 1 read, data returned next cycle.
    step("p1_read", 3'b010, $urandom());
    clr_port(1);
    step("p1_rsp", 3'b000, 32'hDEADBEEF);

`ifndef CIRNO9_SRAM_ARB_RR_EN
    // All three valid: fixed order 1, 2, 0; port 0 is a no-op, port 1 read+write.
    set_port(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    set_port(1, 1'b1, 1'b1, 4'hF, 32'h200, 32'hA5A5A5A5);
    set_port(2, 1'b1, 1'b1, 4'h0, 32'h300, 32'h0);
    step("tri_a", 3'b010, $urandom());
    clr_port(1);
    step("tri_b", 3'b100, $urandom());
    clr_port(2);
    step("tri_c", 3'b001, $urandom());
    clr_port(0);
    step("tri_d", 3'b000, $urandom());
`endif

    // Port 2 partial write; response carries zero data.
    set_port(2, 1'b1, 1'b0, 4'b0011, 32'h40, 32'h12345678);
    step("p2_write", 3'b100, $urandom());
    clr_port(2);
    step("p2_rsp", 3'b000, 32'hCAFEF00D);

    // Build some state, grant a read, then reset on the response cycle.
    set_port(0, 1'b1, 1'b1, 4'h0, 32'h50, 32'h0);
    set_port(1, 1'b1, 1'b1, 4'h0, 32'h60, 32'h0);
    for (int k = 0; k < 5; k++) begin
`ifdef CIRNO9_SRAM_ARB_RR_EN
      step("pre_rst", (k % 2 == 0) ? 3'b001 : 3'b010, $urandom());
`else
      step("pre_rst", 3'b010, $urandom());
`endif
    end
    rst = 1'b1;
    q.delete();
    step("rst_drop", 3'b000, 32'h11111111);
    rst = 1'b0;

`ifdef CIRNO9_SRAM_ARB_RR_EN
    // Pointer back at 0: round-robin 1, 2, 0, 1, 2, 0.
    set_port(2, 1'b1, 1'b0, 4'hF, 32'h70, 32'h55AA55AA);
    for (int k = 0; k < 6; k++) begin
      step("rr", rr_seq[k % 3], $urandom());
    end
`else
    // Counter back at 0: port 1 wins 8 times, port 0 forced on the 9th, then port 1.
    for (int k = 0; k < 8; k++) begin
      step("starve_lose", 3'b010, $urandom());
    end
    step("starve_win", 3'b001, $urandom());
    step("starve_resume", 3'b010, $urandom());
`endif

    clr_port(0);
    clr_port(1);
    clr_port(2);
    step("drain", 3'b000, $urandom());
    step("idle", 3'b000, $urandom());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
